seq_detect_ctrl: RTL and testbench



---
 rtl/seq_detect_ctrl.sv | 177 +++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Run controller for the serial sequence detector: clears/enables the detector for a bounded
// window, counts hits, reports pass/fail. Optional non-overlap mode: SEQ_CTRL_NONOVL_EN.
module seq_detect_ctrl #(
   parameter int WIN_W = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIN_W-1:0] cfg_window,
   input  logic [CNT_W-1:0] cfg_target,
`ifdef SEQ_CTRL_NONOVL_EN
   input  logic             cfg_nonovl,
`endif
   input  logic             start,
   input  logic             abort,
   input  logic             det_hit,
   output logic             det_en,
   output logic             det_clr,
   output logic             busy,
   output logic             done,
   output logic             result_pass,
   output logic [CNT_W-1:0] hit_count
);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [WIN_W-1:0] win_cfg_q;
   logic [CNT_W-1:0] tgt_cfg_q;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0] run_tgt_q, run_tgt_d;
   logic [CNT_W-1:0] hit_q, hit_d, hit_sum;
   logic             pass_q, pass_d;
   logic             det_en_q, det_en_d;
   logic             det_clr_q, det_clr_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             hit_ok;
   logic             nonovl_run;
   logic             cfg_take;

   assign cfg_ready = (state_q == S_IDLE);
   assign cfg_take  = cfg_valid && cfg_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         win_cfg_q <= '0;
         tgt_cfg_q <= '0;
      end else if (cfg_take) begin
         win_cfg_q <= cfg_window;
         tgt_cfg_q <= cfg_target;
      end
   end

`ifdef SEQ_CTRL_NONOVL_EN
   logic nonovl_cfg_q, nonovl_run_q;

   // The run snapshots the mode stored before the start edge, like window and target.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         nonovl_cfg_q <= 1'b0;
         nonovl_run_q <= 1'b0;
      end else begin
         if (cfg_take) begin
            nonovl_cfg_q <= cfg_nonovl;
         end
         if ((state_q == S_IDLE) && start) begin
            nonovl_run_q <= nonovl_cfg_q;
         end
      end
   end
   assign nonovl_run = nonovl_run_q;
`else
   assign nonovl_run = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      win_cnt_d = win_cnt_q;
      run_tgt_d = run_tgt_q;
      hit_d     = hit_q;
      pass_d    = pass_q;
      det_clr_d = 1'b0;
      hit_ok    = 1'b0;
      hit_sum   = hit_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_CLEAR;
               win_cnt_d = win_cfg_q;
               run_tgt_d = tgt_cfg_q;
               hit_d     = '0;
               pass_d    = 1'b0;
            end
         end
         S_CLEAR: begin
            if (abort) begin
               state_d = S_IDLE;
               pass_d  = 1'b0;
            end else if (win_cnt_q == '0) begin
               state_d = S_DONE;
               pass_d  = (run_tgt_q == '0);
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // A hit landing in a non-overlap clear cycle belongs to a suppressed match.
            hit_ok    = det_hit && !(nonovl_run && det_clr_q);
            hit_sum   = (hit_ok && (hit_q != '1)) ? hit_q + CNT_W'(1) : hit_q;
            win_cnt_d = win_cnt_q - WIN_W'(1);
            if (abort) begin
               state_d = S_IDLE;
               pass_d  = 1'b0;
            end else begin
               hit_d = hit_sum;
               if (hit_ok && (run_tgt_q != '0) && (hit_sum == run_tgt_q)) begin
                  state_d = S_DONE;
                  pass_d  = 1'b1;
               end else if (win_cnt_q == WIN_W'(1)) begin
                  state_d = S_DONE;
                  pass_d  = (run_tgt_q == '0);
               end else if (hit_ok && nonovl_run) begin
                  det_clr_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (abort) begin
               pass_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_CLEAR) begin
         det_clr_d = 1'b1;
      end
      det_en_d = (state_d == S_RUN);
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         win_cnt_q <= '0;
         run_tgt_q <= '0;
         hit_q     <= '0;
         pass_q    <= 1'b0;
         det_en_q  <= 1'b0;
         det_clr_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_cnt_q <= win_cnt_d;
         run_tgt_q <= run_tgt_d;
         hit_q     <= hit_d;
         pass_q    <= pass_d;
         det_en_q  <= det_en_d;
         det_clr_q <= det_clr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign det_en      = det_en_q;
   assign det_clr     = det_clr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign result_pass = pass_q;
   assign hit_count   = hit_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: driver pushes expected run summaries from a
// rule-level model, monitor pops one at each end of a run (busy falling).
module tb_seq_detect_ctrl;
   localparam int WIN_W = 16;
   localparam int CNT_W = 8;
`ifdef SEQ_CTRL_NONOVL_EN
   localparam bit NOVL_EN = 1'b1;
`else
   localparam bit NOVL_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [WIN_W-1:0] cfg_window = '0;
   logic [CNT_W-1:0] cfg_target = '0;
`ifdef SEQ_CTRL_NONOVL_EN
   logic             cfg_nonovl = 1'b0;
`endif
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             det_hit = 1'b0;
   logic             det_en, det_clr, busy, done, result_pass;
   logic [CNT_W-1:0] hit_count;

   seq_detect_ctrl #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_window(cfg_window), .cfg_target(cfg_target),
`ifdef SEQ_CTRL_NONOVL_EN
      .cfg_nonovl(cfg_nonovl),
`endif
      .start(start), .abort(abort), .det_hit(det_hit), .det_en(det_en),
      .det_clr(det_clr), .busy(busy), .done(done), .result_pass(result_pass),
      .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int start_cyc;
      int dur;
      int en;
      int clr;
      bit done;
      bit pass;
      int hits;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   m_win = 0;
   int   m_tgt = 0;
   bit   m_nov = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic do_cfg(input int w, input int t, input bit n);
      @(negedge clk);
      cfg_valid  = 1'b1;
      cfg_window = WIN_W'(w);
      cfg_target = CNT_W'(t);
`ifdef SEQ_CTRL_NONOVL_EN
      cfg_nonovl = n;
`endif
      @(posedge clk);
      m_win = w;
      m_tgt = t;
      m_nov = n;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   // Reference: walk the window cycle by cycle applying the run rules to the hit pattern.
   function automatic exp_t model(input bit [63:0] hv, input bit all, input int abort_at);
      exp_t e;
      int   cnt;
      bit   clrp;
      bit   cntd;
      bit   h;
      bit   nov;
      nov    = NOVL_EN && m_nov;
      e.clr  = 1;
      e.done = 1'b1;
      e.pass = 1'b0;
      e.en   = 0;
      e.dur  = 2;
      e.start_cyc = 0;
      cnt  = 0;
      clrp = 1'b0;
      if (m_win == 0) begin
         e.pass = (m_tgt == 0);
      end else begin
         for (int c = 1; c <= m_win; c++) begin
            h = all ? 1'b1 : ((c < 64) ? hv[c] : 1'b0);
            if (c == abort_at) begin
               e.en = c; e.dur = c + 1; e.done = 1'b0; e.pass = 1'b0;
               break;
            end
            cntd = h && !(nov && clrp);
            clrp = 1'b0;
            if (cntd && cnt < 255) cnt++;
            if (cntd && m_tgt != 0 && cnt == m_tgt) begin
               e.en = c; e.dur = c + 2; e.pass = 1'b1;
               break;
            end
            if (c == m_win) begin
               e.en = c; e.dur = c + 2; e.pass = (m_tgt == 0);
               break;
            end
            if (cntd && nov) begin
               clrp = 1'b1;
               e.clr++;
            end
         end
      end
      e.hits = cnt;
      return e;
   endfunction

   task automatic do_run(input bit [63:0] hv, input bit all, input int abort_at,
                         input bit cfg_same, input int nw, input int nt, input bit nn);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      e = model(hv, all, abort_at);
      if (cfg_same) begin
         cfg_valid  = 1'b1;
         cfg_window = WIN_W'(nw);
         cfg_target = CNT_W'(nt);
`ifdef SEQ_CTRL_NONOVL_EN
         cfg_nonovl = nn;
`endif
      end
      @(posedge clk);
      if (cfg_same) begin
         m_win = nw; m_tgt = nt; m_nov = nn;
      end
      @(negedge clk);
      start     = 1'b0;
      cfg_valid = 1'b0;
      det_hit   = 1'($urandom);
      e.start_cyc = cyc;
      sb.push_back(e);
      $display("run: win=%0d tgt=%0d abort_at=%0d -> exp pass=%0d hits=%0d dur=%0d done=%0d",
               m_win, m_tgt, abort_at, e.pass, e.hits, e.dur, e.done);
      for (int c = 1; c <= e.en; c++) begin
         @(negedge clk);
         det_hit    = all ? 1'b1 : ((c < 64) ? hv[c] : 1'b0);
         abort      = (c == abort_at);
         start      = 1'($urandom);
         cfg_valid  = ($urandom_range(0, 3) == 0);
         cfg_window = WIN_W'(1);
         cfg_target = CNT_W'(1);
      end
      @(negedge clk);
      det_hit   = 1'($urandom);
      abort     = 1'b0;
      start     = 1'b0;
      cfg_valid = 1'b0;
      if (e.done) begin
         @(negedge clk);
         det_hit = 1'b0;
      end
   endtask

   // Monitor: accumulate per-run observations, compare when busy falls.
   initial begin
      int   b_cnt, en_cnt, clr_cnt, dn_cnt, idle_bad;
      bit   last_done, prev_busy;
      exp_t e;
      b_cnt = 0; en_cnt = 0; clr_cnt = 0; dn_cnt = 0; idle_bad = 0;
      last_done = 1'b0; prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            b_cnt = 0; en_cnt = 0; clr_cnt = 0; dn_cnt = 0; idle_bad = 0;
            last_done = 1'b0; prev_busy = 1'b0;
         end else begin
            if (busy) begin
               b_cnt++;
               en_cnt  += int'(det_en);
               clr_cnt += int'(det_clr);
               dn_cnt  += int'(done);
               last_done = done;
            end else if (det_en || det_clr || done) begin
               idle_bad++;
            end
            if (cfg_ready == busy) idle_bad++;
            if (prev_busy && !busy) begin
               if (sb.size() == 0) begin
                  chk("unexpected_run", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("end_cycle", cyc, e.start_cyc + e.dur);
                  chk("busy_cycles", b_cnt, e.dur);
                  chk("det_en_cycles", en_cnt, e.en);
                  chk("det_clr_cycles", clr_cnt, e.clr);
                  chk("done_pulses", dn_cnt, int'(e.done));
                  chk("done_in_last_cycle", int'(last_done), int'(e.done));
                  chk("result_pass", int'(result_pass), int'(e.pass));
                  chk("hit_count", int'(hit_count), e.hits);
                  chk("idle_outputs", idle_bad, 0);
               end
               b_cnt = 0; en_cnt = 0; clr_cnt = 0; dn_cnt = 0; idle_bad = 0;
               last_done = 1'b0;
            end
            prev_busy = busy;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, t, ab;
      bit [63:0] hv;
      repeat (3) @(negedge clk);
      chk("rst_cfg_ready", int'(cfg_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_det_en", int'(det_en), 0);
      chk("rst_det_clr", int'(det_clr), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pass", int'(result_pass), 0);
      chk("rst_hits", int'(hit_count), 0);
      rstn = 1'b1;

      do_run(64'h0, 1'b0, 0, 1'b0, 0, 0, 1'b0);          // stored window 0, target 0
      do_cfg(20, 3, 1'b0);
      do_run(64'h8210, 1'b0, 0, 1'b0, 0, 0, 1'b0);       // hits 4,9,15
      do_cfg(10, 5, 1'b0);
      do_run(64'h88, 1'b0, 0, 1'b0, 0, 0, 1'b0);         // 2 hits, fail
      do_cfg(8, 0, 1'b0);
      do_run(64'h0, 1'b1, 0, 1'b0, 0, 0, 1'b0);          // count-only, all hits
      do_cfg(8, 4, 1'b0);
      do_run(64'hE, 1'b0, 3, 1'b0, 0, 0, 1'b0);          // abort with hit at 3
      do_run(64'h0, 1'b1, 0, 1'b0, 0, 0, 1'b0);          // config survived busy offers
      do_cfg(6, 1, 1'b0);
      do_run(64'h40, 1'b0, 0, 1'b0, 0, 0, 1'b0);         // hit on last cycle
      do_cfg(0, 2, 1'b0);
      do_run(64'h0, 1'b0, 0, 1'b0, 0, 0, 1'b0);          // window 0, target 2
      do_cfg(10, 0, 1'b1);
      do_run(64'h1C, 1'b0, 0, 1'b0, 0, 0, 1'b0);         // consecutive hits 2,3,4
      do_cfg(5, 0, 1'b0);
      do_run(64'h0, 1'b0, 0, 1'b1, 3, 1, 1'b0);          // config on start edge
      do_run(64'h0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
      do_cfg(300, 0, 1'b0);
      do_run(64'h0, 1'b1, 0, 1'b0, 0, 0, 1'b0);          // saturation at 255

      for (int i = 0; i < 24; i++) begin
         w  = $urandom_range(0, 40);
         t  = $urandom_range(0, 6);
         do_cfg(w, t, 1'($urandom));
         hv = {$urandom, $urandom};
         ab = ($urandom_range(0, 4) == 0 && w > 0) ? $urandom_range(1, w) : 0;
         do_run(hv, 1'b0, ab, ($urandom_range(0, 3) == 0),
                $urandom_range(0, 20), $urandom_range(0, 4), 1'($urandom));
      end

      // Asynchronous reset in the middle of a run.
      do_cfg(30, 0, 1'b0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      det_hit = 1'b1;
      repeat (5) @(negedge clk);
      chk("pre_reset_det_en", int'(det_en), 1);
      chk("pre_reset_hits", int'(hit_count), 4);
      #2 rstn = 1'b0;
      #1;
      chk("async_rst_det_en", int'(det_en), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_hits", int'(hit_count), 0);
      chk("async_rst_cfg_ready", int'(cfg_ready), 1);
      @(negedge clk);
      det_hit = 1'b0;
      rstn    = 1'b1;
      m_win = 0; m_tgt = 0; m_nov = 1'b0;
      do_run(64'h0, 1'b0, 0, 1'b0, 0, 0, 1'b0);          // stored config back to zero

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
